// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller for the EX stage.
//
// Owns the architectural HI/LO registers. MULT/MULTU run as shift-add
// iterations and DIV/DIVU as restoring-divide iterations, one step per cycle.
// A final FIX cycle applies sign correction and writes HI/LO. The block also
// serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline when an HI/LO access
// arrives while an operation is in flight.
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-low reset
//   Ins          instruction in EX
//   issue_valid  Ins/Rdata valid this cycle
//   Rdata1       rs value (multiplicand / dividend / MT source)
//   Rdata2       rt value (multiplier / divisor)
//   stall        combinational; hold EX and earlier stages
//   busy         operation in flight
//   HIreg/LOreg  architectural HI/LO
//   mf_data      combinational MFHI/MFLO result (0 when not serving one)
//   div_zero     one-cycle pulse after a divide by zero completes
//
// Optional feature: define MDU_EARLY_OUT_EN to let multiplies finish as soon
// as the remaining multiplier magnitude is zero (after at least one step).
module mdu_ctrl #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [31:0]     Ins,
    input  logic            issue_valid,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] HIreg,
    output logic [XLEN-1:0] LOreg,
    output logic [XLEN-1:0] mf_data,
    output logic            div_zero
);
    localparam int unsigned   CW   = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_nxt;

    // Decode
    logic [5:0] funct;
    logic       special;
    logic       is_mfhi, is_mthi, is_mflo, is_mtlo, is_mult, is_div, is_mdu;
    logic       signed_op, accept;
    logic       unused_ins;

    assign funct      = Ins[5:0];
    assign special    = issue_valid && (Ins[31:26] == 6'h00);
    assign is_mfhi    = special && (funct == 6'h10);
    assign is_mthi    = special && (funct == 6'h11);
    assign is_mflo    = special && (funct == 6'h12);
    assign is_mtlo    = special && (funct == 6'h13);
    assign is_mult    = special && ((funct == 6'h18) || (funct == 6'h19));
    assign is_div     = special && ((funct == 6'h1A) || (funct == 6'h1B));
    assign is_mdu     = is_mfhi || is_mthi || is_mflo || is_mtlo || is_mult || is_div;
    assign signed_op  = ~funct[0];
    assign unused_ins = ^Ins[25:6];

    assign busy   = (state != IDLE);
    assign stall  = is_mdu && busy;
    assign accept = !busy && (is_mult || is_div);

    // Operand magnitudes for the unsigned iteration core
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    assign a_neg = signed_op && Rdata1[XLEN-1];
    assign b_neg = signed_op && Rdata2[XLEN-1];
    assign mag_a = a_neg ? -Rdata1 : Rdata1;
    assign mag_b = b_neg ? -Rdata2 : Rdata2;

    // Iteration state
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] prod, mcand;
    logic [XLEN-1:0]   mplier, rem, quo, divisor, dividend;
    logic              op_div, neg_lo, neg_hi, dz;
    logic              mul_last;

    // Restoring step: shift next dividend bit into the partial remainder and
    // subtract if it fits (no borrow out of the extra top bit).
    logic [XLEN:0] rshift, rdiff;
    assign rshift = {rem, quo[XLEN-1]};
    assign rdiff  = rshift - {1'b0, divisor};

`ifdef MDU_EARLY_OUT_EN
    assign mul_last = (cnt == LAST) || (mplier[XLEN-1:1] == '0);
`else
    assign mul_last = (cnt == LAST);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_div ? DIV : MUL;
            MUL:     if (mul_last) state_nxt = FIX;
            DIV:     if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            dividend <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt      <= '0;
                    op_div   <= is_div;
                    neg_lo   <= a_neg ^ b_neg;
                    neg_hi   <= a_neg;
                    dz       <= is_div && (Rdata2 == '0);
                    dividend <= Rdata1;
                    prod     <= '0;
                    mcand    <= {{XLEN{1'b0}}, mag_a};
                    mplier   <= mag_b;
                    rem      <= '0;
                    quo      <= mag_a;
                    divisor  <= mag_b;
                end
                MUL: begin
                    cnt    <= cnt + CW'(1);
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                DIV: begin
                    cnt <= cnt + CW'(1);
                    if (!rdiff[XLEN]) begin
                        rem <= rdiff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rshift[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign-corrected result presented during FIX
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   res_hi, res_lo;

    always_comb begin
        prod_s = neg_lo ? -prod : prod;
        res_hi = prod_s[2*XLEN-1:XLEN];
        res_lo = prod_s[XLEN-1:0];
        if (op_div) begin
            if (dz) begin
                res_lo = '1;
                res_hi = dividend;
            end else begin
                res_lo = neg_lo ? -quo : quo;
                res_hi = neg_hi ? -rem : rem;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            HIreg    <= '0;
            LOreg    <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= (state == FIX) && op_div && dz;
            if (state == FIX) begin
                HIreg <= res_hi;
                LOreg <= res_lo;
            end else if (!busy) begin
                if (is_mthi) HIreg <= Rdata1;
                if (is_mtlo) LOreg <= Rdata1;
            end
        end
    end

    always_comb begin
        mf_data = '0;
        if (!busy && is_mfhi)      mf_data = HIreg;
        else if (!busy && is_mflo) mf_data = LOreg;
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. The driver computes each
// expected HI/LO/div_zero/latency with plain 64-bit arithmetic at issue time
// and queues it; a monitor pops and compares when an operation completes or
// an MFHI/MFLO is served.
module tb_mdu_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Ins;
    logic        issue_valid;
    logic [31:0] Rdata1, Rdata2;
    logic        stall, busy, div_zero;
    logic [31:0] HIreg, LOreg, mf_data;

    mdu_ctrl #(.XLEN(32), .ITER(32)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .issue_valid(issue_valid),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .stall(stall), .busy(busy),
        .HIreg(HIreg), .LOreg(LOreg), .mf_data(mf_data), .div_zero(div_zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        opq[$];
    logic [31:0] mfq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'h00, mid, f};
    endfunction

    function automatic bit is_mdu_ins(input logic [31:0] i);
        return (i[31:26] == 6'h00) &&
               ((i[5:0] >= 6'h10 && i[5:0] <= 6'h13) || (i[5:0] >= 6'h18 && i[5:0] <= 6'h1B));
    endfunction

    function automatic bit is_mf_ins(input logic [31:0] i);
        return (i[31:26] == 6'h00) && (i[5:0] == 6'h10 || i[5:0] == 6'h12);
    endfunction

    // Reference model: arithmetic result of an accepted MULT/DIV class op
    function automatic void model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          sa, sb;
        logic [31:0] m;
        int          k;
        e.dz  = 1'b0;
        e.lat = 33;
        case (f)
            6'h18: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            6'h19: begin
                u = {32'h0, a} * {32'h0, b};
                {e.hi, e.lo} = u;
            end
            6'h1A: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000; e.hi = 32'h0;
                end else begin
                    sa = a; sb = b;
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
`ifdef MDU_EARLY_OUT_EN
        if (f == 6'h18 || f == 6'h19) begin
            m = (f == 6'h18 && b[31]) ? -b : b;
            k = 1;
            for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
            e.lat = k + 1;
        end
`else
        m = '0;
        k = 0;
`endif
        ref_hi = e.hi;
        ref_lo = e.lo;
        opq.push_back(e);
    endfunction

    // Present one instruction, hold it while stalled, return #1 after the
    // accepting edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        Ins = ins; Rdata1 = a; Rdata2 = b; issue_valid = 1'b1;
        if (is_mdu_ins(ins)) begin
            case (ins[5:0])
                6'h10: mfq.push_back(ref_hi);
                6'h12: mfq.push_back(ref_lo);
                6'h11: ref_hi = a;
                6'h13: ref_lo = a;
                default: model_op(ins[5:0], a, b);
            endcase
        end
        forever begin
            @(negedge CLK);
            if (!stall) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL issue_timeout: stall still %b after %0d cycles, required 0", stall, n);
                break;
            end
        end
        @(posedge CLK); #1;
        issue_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        Ins = rtype(6'h18);   // MDU encoding with issue_valid low must be ignored
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor / scoreboard
    bit   prev_busy = 1'b0;
    bit   dz_chk    = 1'b0;
    int   bcnt      = 0;
    exp_t me;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev_busy = 1'b0; bcnt = 0; dz_chk = 1'b0;
                continue;
            end
            if (issue_valid && is_mdu_ins(Ins)) chk("stall_mdu", stall, busy);
            else                                chk("stall_other", stall, 0);
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                if (opq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: completion with empty queue at %0t", $time);
                end else begin
                    me = opq.pop_front();
                    chk("HI", HIreg, me.hi);
                    chk("LO", LOreg, me.lo);
                    chk("div_zero", div_zero, me.dz);
                    chk("latency", bcnt, me.lat);
                end
                bcnt = 0;
                dz_chk = 1'b1;
            end else if (dz_chk) begin
                chk("div_zero_width", div_zero, 0);
                dz_chk = 1'b0;
            end
            if (issue_valid && is_mf_ins(Ins) && !stall) begin
                if (mfq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mf: no expectation queued at %0t", $time);
                end else begin
                    chk("mf_data", mf_data, mfq.pop_front());
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        int r, n;
        logic [31:0] ins;
        RST = 1'b0; issue_valid = 1'b0; Ins = '0; Rdata1 = '0; Rdata2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_HI", HIreg, 0);
        chk("reset_LO", LOreg, 0);
        chk("reset_busy", busy, 0);
        chk("reset_div_zero", div_zero, 0);
        RST = 1'b1;
        idle(2);

        // Directed cases
        issue(rtype(6'h19), 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(rtype(6'h18), -32'd3, 32'd7);
        issue(rtype(6'h1A), -32'd7, 32'd2);
        issue(rtype(6'h1A), 32'h80000000, 32'hFFFFFFFF);
        issue(rtype(6'h1B), 32'd10, 32'd0);
        issue(rtype(6'h12), 0, 0);
        issue(rtype(6'h18), 32'h12345, -32'd99);
        issue(rtype(6'h20), 32'd1, 32'd2);          // ADD while busy: no stall
        idle(3);
        issue(rtype(6'h12), 0, 0);                  // MFLO waits for the MULT
        issue(rtype(6'h10), 0, 0);
        issue(rtype(6'h19), 32'd3, 32'd5);

        // Reset in the middle of a DIVU
        issue(rtype(6'h1B), 32'd100, 32'd7);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_HI", HIreg, 0);
        chk("midreset_LO", LOreg, 0);
        opq.delete();
        ref_hi = '0; ref_lo = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(1);
        issue(rtype(6'h11), 32'h12345678, 0);
        chk("mthi_HI", HIreg, 32'h12345678);
        issue(rtype(6'h10), 0, 0);
        issue(rtype(6'h12), 0, 0);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: issue(rtype(6'h18), rnd_op(), rnd_op());
                1: issue(rtype(6'h19), rnd_op(), rnd_op());
                2: issue(rtype(6'h1A), rnd_op(), rnd_op());
                3: issue(rtype(6'h1B), rnd_op(), rnd_op());
                4: issue(rtype(6'h11), rnd_op(), rnd_op());
                5: issue(rtype(6'h13), rnd_op(), rnd_op());
                6: issue(rtype(6'h10), rnd_op(), rnd_op());
                7: issue(rtype(6'h12), rnd_op(), rnd_op());
                8: begin
                    if ($urandom_range(0, 1) == 0) ins = rtype(6'h20);
                    else begin
                        ins = $urandom;
                        ins[31:26] = 6'($urandom_range(1, 63));
                        ins[5:0]   = 6'($urandom_range(6'h18, 6'h1B));
                    end
                    issue(ins, rnd_op(), rnd_op());
                end
                default: idle($urandom_range(0, 3));
            endcase
        end

        // Drain
        n = 0;
        while (opq.size() != 0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_opq", opq.size(), 0);
        chk("drain_mfq", mfq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
